// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_transceiver TX channel between four
// byte-stream requesters. Round-robin arbitration, optional packet lock,
// and at most one byte in flight between tx_wr and tx_done.
//
// Handshake: requester i offers a byte by holding req_valid[i] high. The
// byte (req_data[8i+7:8i], req_last[i]) is taken on the rising edge that
// ends the single cycle where req_ready[i] is high. req_ready[i] rises only
// when req_valid[i] & req_enable[i] are both high, and it never depends on
// req_data or req_last.
module uart_tx_arbiter #(
   parameter int unsigned lock_timeout = 4096
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic [3:0]  req_valid,
   input  logic [31:0] req_data,
   input  logic [3:0]  req_last,
   input  logic [3:0]  req_enable,
   output logic [3:0]  req_ready,
   output logic [7:0]  tx_data,
   output logic        tx_wr,
   input  logic        tx_done,
   output logic [1:0]  grant,
   output logic        busy,
   output logic        locked,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   localparam logic [15:0] TMO = 16'(lock_timeout);

   state_t      state_q, state_d;
   logic [1:0]  grant_q, grant_d;
   logic [1:0]  rr_q, rr_d;
   logic        locked_q, locked_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic        tx_wr_q, tx_wr_d;
   logic [15:0] cnt_q, cnt_d;

   logic [3:0]  cand;
   logic        pick_valid;
   logic [1:0]  pick_idx;
   logic        xfer;
   logic [7:0]  cur_byte;
   logic [15:0] cnt_inc;

   assign cand     = req_valid & req_enable;
   assign xfer     = req_valid[grant_q] & req_enable[grant_q];
   assign cur_byte = req_data[{grant_q, 3'b000} +: 8];
   assign cnt_inc  = cnt_q + 16'd1;

   // Round-robin pick: first candidate scanning rr+1, rr+2, rr+3, rr.
   // Iterating from the farthest offset down lets the nearest one win.
   always_comb begin
      logic [1:0] idx;
      pick_valid = 1'b0;
      pick_idx   = rr_q;
      idx        = rr_q;
      for (int k = 4; k >= 1; k--) begin
         idx = rr_q + 2'(k);
         if (cand[idx]) begin
            pick_valid = 1'b1;
            pick_idx   = idx;
         end
      end
   end

   // State register: every piece of arbiter state, synchronous reset.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q   <= S_IDLE;
         grant_q   <= 2'd0;
         rr_q      <= 2'd3;
         locked_q  <= 1'b0;
         tx_data_q <= 8'h00;
         tx_wr_q   <= 1'b0;
         cnt_q     <= 16'd0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         rr_q      <= rr_d;
         locked_q  <= locked_d;
         tx_data_q <= tx_data_d;
         tx_wr_q   <= tx_wr_d;
         cnt_q     <= cnt_d;
      end
   end

   // Next-state logic: arbitration, byte transfer, lock hold and release.
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      rr_d      = rr_q;
      locked_d  = locked_q;
      tx_data_d = tx_data_q;
      tx_wr_d   = 1'b0;
      cnt_d     = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (pick_valid) begin
               grant_d = pick_idx;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            if (xfer) begin
               tx_data_d = cur_byte;
               tx_wr_d   = 1'b1;
               locked_d  = ~req_last[grant_q];
               cnt_d     = 16'd0;
               state_d   = S_WAIT;
            end else if (!locked_q) begin
               // Requester vanished or was masked after the grant.
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_inc;
               if ((cnt_inc == TMO) || !req_enable[grant_q]) begin
                  locked_d = 1'b0;
                  rr_d     = grant_q;
                  cnt_d    = 16'd0;
                  state_d  = S_IDLE;
               end
            end
         end
         S_WAIT: begin
            if (tx_done) begin
               if (locked_q) begin
                  state_d = S_LOAD;
               end else begin
                  rr_d    = grant_q;
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs: ready strobe is combinational in LOAD, the rest are registers.
   always_comb begin
      req_ready = 4'b0000;
      if ((state_q == S_LOAD) && xfer) begin
         req_ready = 4'b0001 << grant_q;
      end
      busy      = (state_q != S_IDLE);
      dbg_state = state_q;
      tx_data   = tx_data_q;
      tx_wr     = tx_wr_q;
      grant     = grant_q;
      locked    = locked_q;
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scenario tasks for uart_tx_arbiter with a
// transaction-level model of which byte goes out next.
module tb_uart_tx_arbiter;

   logic        sys_clk = 1'b0;
   logic        sys_rst = 1'b1;
   logic [3:0]  req_valid = 4'b0;
   logic [31:0] req_data = 32'b0;
   logic [3:0]  req_last = 4'b0;
   logic [3:0]  req_enable = 4'hf;
   logic [3:0]  req_ready;
   logic [7:0]  tx_data;
   logic        tx_wr;
   logic        tx_done = 1'b0;
   logic [1:0]  grant;
   logic        busy;
   logic        locked;
   logic [1:0]  dbg_state;

   int n_tests = 0;
   int n_fail  = 0;

   // Model state: priority pointer and expected {grant, locked, data}.
   int          model_rr = 3;
   logic [10:0] exp_q[$];
   // Per-requester pending bytes {last, data}.
   logic [8:0]  drv_q[4][$];

   // Snapshots taken at the falling edge.
   logic [3:0]  s_ready, s_valid, s_en;
   logic        s_wr, s_busy, s_locked, s_done;
   logic [7:0]  s_data;
   logic [1:0]  s_grant;

   uart_tx_arbiter #(.lock_timeout(16)) dut (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_last   (req_last),
      .req_enable (req_enable),
      .req_ready  (req_ready),
      .tx_data    (tx_data),
      .tx_wr      (tx_wr),
      .tx_done    (tx_done),
      .grant      (grant),
      .busy       (busy),
      .locked     (locked),
      .dbg_state  (dbg_state)
   );

   always #5 sys_clk = ~sys_clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic drive_inputs();
      for (int i = 0; i < 4; i++) begin
         if (drv_q[i].size() > 0) begin
            req_valid[i]       = 1'b1;
            req_data[8*i +: 8] = drv_q[i][0][7:0];
            req_last[i]        = drv_q[i][0][8];
         end else begin
            req_valid[i]       = 1'b0;
            req_data[8*i +: 8] = 8'h00;
            req_last[i]        = 1'b0;
         end
      end
   endtask

   // Sample one cycle at the falling edge, then after the rising edge
   // retire accepted bytes and set tx_done for the following cycle.
   task automatic tick(input logic dn);
      logic [8:0] tmp;
      @(negedge sys_clk);
      s_ready  = req_ready;
      s_valid  = req_valid;
      s_en     = req_enable;
      s_wr     = tx_wr;
      s_data   = tx_data;
      s_grant  = grant;
      s_busy   = busy;
      s_locked = locked;
      s_done   = tx_done;
      @(posedge sys_clk);
      #1;
      tx_done = dn;
      for (int i = 0; i < 4; i++) begin
         if (s_ready[i] && drv_q[i].size() > 0) tmp = drv_q[i].pop_front();
      end
      drive_inputs();
   endtask

   task automatic apply_reset();
      sys_rst = 1'b1;
      tx_done = 1'b0;
      for (int i = 0; i < 4; i++) drv_q[i].delete();
      exp_q.delete();
      drive_inputs();
      tick(1'b0);
      tick(1'b0);
      sys_rst  = 1'b0;
      model_rr = 3;
   endtask

   // Whole packets leave in round-robin order among enabled requesters
   // with bytes waiting; priority moves to the requester just served.
   task automatic model_build(input logic [3:0] en);
      logic [8:0] m[4][$];
      logic [8:0] b;
      logic [1:0] idx;
      int         pick;
      for (int i = 0; i < 4; i++) m[i] = drv_q[i];
      for (int guard = 0; guard < 64; guard++) begin
         pick = -1;
         for (int k = 1; k <= 4; k++) begin
            idx = 2'((model_rr + k) % 4);
            if (pick < 0 && en[idx] && m[idx].size() > 0) pick = int'(idx);
         end
         if (pick < 0) break;
         do begin
            b = m[pick].pop_front();
            exp_q.push_back({2'(pick), ~b[8], b[7:0]});
         end while (!b[8] && m[pick].size() > 0);
         model_rr = pick;
      end
   endtask

   // Runs until every expected byte has gone out and been completed.
   task automatic run_traffic(input int dmin, input int dmax, input int budget);
      int          cyc = 0;
      int          dcnt = 0;
      logic        pending = 1'b0;
      logic        done_sent = 1'b0;
      logic        dn;
      logic [10:0] e;
      while ((exp_q.size() != 0 || pending) && cyc < budget) begin
         dn = 1'b0;
         if (pending && !done_sent) begin
            dcnt--;
            if (dcnt <= 0) begin
               dn = 1'b1;
               done_sent = 1'b1;
            end
         end
         tick(dn);
         cyc++;
         n_tests++;
         if ((s_ready & ~(s_valid & s_en)) != 4'b0 || $countones(s_ready) > 1) begin
            n_fail++;
            $display("FAIL ready_proto: got ready=%b with valid=%b enable=%b", s_ready, s_valid, s_en);
         end
         if (s_wr) begin
            n_tests++;
            if (pending) begin
               n_fail++;
               $display("FAIL wr_in_flight: got tx_wr=1 expected 0 before tx_done");
            end else if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL extra_wr: got tx_wr data %h expected no write", s_data);
            end else begin
               e = exp_q.pop_front();
               if ({s_grant, s_locked, s_data} !== e) begin
                  n_fail++;
                  $display("FAIL tx_byte: got grant=%0d locked=%b data=%h expected grant=%0d locked=%b data=%h",
                           s_grant, s_locked, s_data, e[10:9], e[8], e[7:0]);
               end
            end
         end
         if (s_done) begin
            pending   = 1'b0;
            done_sent = 1'b0;
         end
         if (s_wr) begin
            pending = 1'b1;
            dcnt    = $urandom_range(dmax, dmin);
         end
      end
      n_tests++;
      if (exp_q.size() != 0 || pending) begin
         n_fail++;
         $display("FAIL traffic_drain: got %0d bytes left expected 0 within %0d cycles", exp_q.size(), budget);
      end
      exp_q.delete();
   endtask

   task automatic test_reset();
      apply_reset();
      tick(1'b0);
      n_tests++;
      if ({s_ready, s_wr, s_data, s_grant, s_busy, s_locked} !== 17'b0) begin
         n_fail++;
         $display("FAIL reset_state: got ready=%b wr=%b data=%h grant=%0d busy=%b locked=%b expected all zero",
                  s_ready, s_wr, s_data, s_grant, s_busy, s_locked);
      end
   endtask

   task automatic test_single_byte();
      drv_q[0].push_back({1'b1, 8'h55});
      drive_inputs();
      tick(1'b0);
      tick(1'b0);
      n_tests++;
      if (s_ready !== 4'b0001 || s_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL single_ready: got ready=%b busy=%b expected 0001 1", s_ready, s_busy);
      end
      tick(1'b0);
      n_tests++;
      if ({s_wr, s_data, s_grant, s_locked, s_ready} !== {1'b1, 8'h55, 2'd0, 1'b0, 4'b0}) begin
         n_fail++;
         $display("FAIL single_wr: got wr=%b data=%h grant=%0d locked=%b ready=%b expected 1 55 0 0 0000",
                  s_wr, s_data, s_grant, s_locked, s_ready);
      end
      tick(1'b0);
      tick(1'b0);
      tick(1'b0);
      n_tests++;
      if (s_busy !== 1'b1 || s_wr !== 1'b0) begin
         n_fail++;
         $display("FAIL single_wait: got busy=%b wr=%b expected 1 0", s_busy, s_wr);
      end
      tick(1'b1);
      tick(1'b0);
      tick(1'b0);
      n_tests++;
      if ({s_busy, s_locked, s_grant} !== 4'b0) begin
         n_fail++;
         $display("FAIL single_done: got busy=%b locked=%b grant=%0d expected 0 0 0", s_busy, s_locked, s_grant);
      end
   endtask

   task automatic test_round_robin();
      apply_reset();
      drv_q[0].push_back({1'b1, 8'hA0});
      drv_q[0].push_back({1'b1, 8'hA0});
      drv_q[1].push_back({1'b1, 8'hA1});
      drv_q[2].push_back({1'b1, 8'hA2});
      drv_q[3].push_back({1'b1, 8'hA3});
      drive_inputs();
      model_build(4'hf);
      run_traffic(19, 19, 400);
   endtask

   task automatic test_packet_lock();
      drv_q[1].push_back({1'b0, 8'h10});
      drv_q[1].push_back({1'b0, 8'h11});
      drv_q[1].push_back({1'b1, 8'h12});
      drv_q[2].push_back({1'b1, 8'h20});
      drive_inputs();
      model_build(4'hf);
      run_traffic(2, 6, 400);
   endtask

   task automatic test_enable_mask();
      int bad0 = 0;
      req_enable = 4'b1110;
      drv_q[0].push_back({1'b1, 8'hB0});
      drv_q[1].push_back({1'b1, 8'hB1});
      drv_q[2].push_back({1'b1, 8'hB2});
      drv_q[3].push_back({1'b1, 8'hB3});
      drive_inputs();
      model_build(4'b1110);
      run_traffic(1, 5, 400);
      for (int c = 0; c < 6; c++) begin
         tick(1'b0);
         if (s_ready[0] || s_busy) bad0++;
      end
      n_tests++;
      if (bad0 != 0) begin
         n_fail++;
         $display("FAIL mask_hold: got %0d active cycles for masked req0 expected 0", bad0);
      end
      req_enable = 4'hf;
      model_build(4'hf);
      run_traffic(1, 5, 200);
   endtask

   task automatic test_lock_timeout();
      int   k = 0;
      logic stop = 1'b0;
      logic bad1 = 1'b0;
      apply_reset();
      drv_q[1].push_back({1'b0, 8'h33});
      drv_q[2].push_back({1'b1, 8'h44});
      drive_inputs();
      s_wr = 1'b0;
      for (int c = 0; c < 10 && !s_wr; c++) tick(1'b0);
      n_tests++;
      if ({s_wr, s_grant, s_locked, s_data} !== {1'b1, 2'd1, 1'b1, 8'h33}) begin
         n_fail++;
         $display("FAIL tmo_first: got wr=%b grant=%0d locked=%b data=%h expected 1 1 1 33",
                  s_wr, s_grant, s_locked, s_data);
      end
      tick(1'b0);
      tick(1'b0);
      tick(1'b1);
      tick(1'b0);
      for (int c = 0; c < 40 && !stop; c++) begin
         tick(1'b0);
         if (s_ready[1]) bad1 = 1'b1;
         if (s_locked) k++;
         else stop = 1'b1;
      end
      n_tests++;
      if (k != 16) begin
         n_fail++;
         $display("FAIL tmo_cycles: got %0d locked LOAD cycles expected 16", k);
      end
      n_tests++;
      if (s_busy !== 1'b0 || bad1 !== 1'b0) begin
         n_fail++;
         $display("FAIL tmo_release: got busy=%b req1_ready_seen=%b expected 0 0", s_busy, bad1);
      end
      model_rr = 1;
      model_build(4'hf);
      run_traffic(1, 4, 200);
   endtask

   task automatic test_reset_mid_wait();
      drv_q[3].push_back({1'b1, 8'h77});
      drive_inputs();
      s_wr = 1'b0;
      for (int c = 0; c < 10 && !s_wr; c++) tick(1'b0);
      n_tests++;
      if (s_wr !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_pre_wr: got tx_wr=%b expected 1", s_wr);
      end
      tick(1'b0);
      sys_rst = 1'b1;
      tick(1'b0);
      sys_rst = 1'b0;
      tick(1'b0);
      n_tests++;
      if ({s_ready, s_wr, s_data, s_grant, s_busy, s_locked} !== 17'b0) begin
         n_fail++;
         $display("FAIL rst_mid_wait: got ready=%b wr=%b data=%h grant=%0d busy=%b locked=%b expected all zero",
                  s_ready, s_wr, s_data, s_grant, s_busy, s_locked);
      end
      model_rr = 3;
      drv_q[0].push_back({1'b1, 8'hC0});
      drv_q[1].push_back({1'b1, 8'hC1});
      drv_q[2].push_back({1'b1, 8'hC2});
      drv_q[3].push_back({1'b1, 8'hC3});
      drive_inputs();
      model_build(4'hf);
      run_traffic(1, 6, 400);
   endtask

   task automatic test_random();
      int         np, len;
      logic [7:0] d;
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 4; i++) begin
            np = $urandom_range(2, 0);
            for (int p = 0; p < np; p++) begin
               len = $urandom_range(3, 1);
               for (int b = 0; b < len; b++) begin
                  d = 8'($urandom_range(255, 0));
                  drv_q[i].push_back({(b == len - 1), d});
               end
            end
         end
         drive_inputs();
         model_build(4'hf);
         run_traffic(1, 8, 4000);
      end
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_round_robin();
      test_packet_lock();
      test_enable_mask();
      test_lock_timeout();
      test_reset_mid_wait();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
